// File: rtl/param_reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback over several ports,
// in-order single commit per cycle with mispredict and external flush recovery.
module param_reorder_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned WB_PORTS    = 4,
    parameter int unsigned FULL_MARGIN = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_dest,
    input  logic [1:0]               alloc_kind,
    output logic                     alloc_ready,
    output logic [IDX_W-1:0]         alloc_tag,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]   wb_value,
    input  logic [WB_PORTS-1:0]      wb_mispredict,
    input  logic                     flush_in,
    output logic                     commit_valid,
    output logic [IDX_W-1:0]         commit_tag,
    output logic [4:0]               commit_dest,
    output logic [31:0]              commit_value,
    output logic [1:0]               commit_kind,
    output logic                     commit_mispredict,
    output logic [IDX_W:0]           rob_count,
    output logic                     rob_empty
);

    localparam logic [IDX_W+1:0] ReadyLimit = (IDX_W+2)'(DEPTH - FULL_MARGIN);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] mispred_q, mispred_d;
    logic [4:0]       dest_q  [DEPTH];
    logic [4:0]       dest_d  [DEPTH];
    logic [1:0]       kind_q  [DEPTH];
    logic [1:0]       kind_d  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [31:0]      value_d [DEPTH];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic             cvalid_q, cvalid_d;
    logic [IDX_W-1:0] ctag_q, ctag_d;
    logic [4:0]       cdest_q, cdest_d;
    logic [31:0]      cvalue_q, cvalue_d;
    logic [1:0]       ckind_q, ckind_d;
    logic             cmisp_q, cmisp_d;

    logic             do_alloc;
    logic             do_commit;
    logic [IDX_W-1:0] wtag;

    assign alloc_ready = {1'b0, count_q} < ReadyLimit;
    assign alloc_tag   = tail_q;
    assign rob_count   = count_q;
    assign rob_empty   = (count_q == '0);

    assign commit_valid      = cvalid_q;
    assign commit_tag        = ctag_q;
    assign commit_dest       = cdest_q;
    assign commit_value      = cvalue_q;
    assign commit_kind       = ckind_q;
    assign commit_mispredict = cmisp_q;

    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        dest_d    = dest_q;
        kind_d    = kind_q;
        value_d   = value_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        cvalid_d  = cvalid_q;
        ctag_d    = ctag_q;
        cdest_d   = cdest_q;
        cvalue_d  = cvalue_q;
        ckind_d   = ckind_q;
        cmisp_d   = cmisp_q;
        wtag      = '0;
        do_alloc  = alloc_valid && alloc_ready;
        // done is sampled before this edge's writeback, so there is no wb-to-commit bypass
        do_commit = (count_q != '0) && valid_q[head_q] && done_q[head_q];

        if (rdy) begin
            cvalid_d = 1'b0;
            if (flush_in) begin
                valid_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                // Descending order so the lowest-numbered port is applied last and wins
                for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                    wtag = wb_tag[p*IDX_W +: IDX_W];
                    if (wb_valid[p] && valid_q[wtag]) begin
                        done_d[wtag]    = 1'b1;
                        value_d[wtag]   = wb_value[p*32 +: 32];
                        mispred_d[wtag] = wb_mispredict[p];
                    end
                end

                if (do_commit) begin
                    cvalid_d        = 1'b1;
                    ctag_d          = head_q;
                    cdest_d         = dest_q[head_q];
                    cvalue_d        = value_q[head_q];
                    ckind_d         = kind_q[head_q];
                    cmisp_d         = mispred_q[head_q];
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                end

                if (do_commit && mispred_q[head_q]) begin
                    valid_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end else begin
                    if (do_alloc) begin
                        valid_d[tail_q]   = 1'b1;
                        done_d[tail_q]    = 1'b0;
                        mispred_d[tail_q] = 1'b0;
                        dest_d[tail_q]    = alloc_dest;
                        kind_d[tail_q]    = alloc_kind;
                        tail_d            = tail_q + 1'b1;
                    end
                    count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            cvalid_q  <= 1'b0;
            ctag_q    <= '0;
            cdest_q   <= '0;
            cvalue_q  <= '0;
            ckind_q   <= '0;
            cmisp_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cvalid_q  <= cvalid_d;
            ctag_q    <= ctag_d;
            cdest_q   <= cdest_d;
            cvalue_q  <= cvalue_d;
            ckind_q   <= ckind_d;
            cmisp_q   <= cmisp_d;
        end
    end

    // Payload storage is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        kind_q  <= kind_d;
        value_q <= value_d;
    end

endmodule

// File: tb/tb_param_reorder_buffer.sv
// Randomized bench for param_reorder_buffer against a queue-based in-order model.
module tb_param_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int WB     = 4;
    localparam int MARGIN = 3;

    logic             clk = 1'b0;
    logic             rst, rdy, alloc_valid, flush_in;
    logic [4:0]       alloc_dest;
    logic [1:0]       alloc_kind;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_tag;
    logic [WB-1:0]    wb_valid, wb_mispredict;
    logic [WB*IDX_W-1:0] wb_tag;
    logic [WB*32-1:0] wb_value;
    logic             commit_valid, commit_mispredict, rob_empty;
    logic [IDX_W-1:0] commit_tag;
    logic [4:0]       commit_dest;
    logic [31:0]      commit_value;
    logic [1:0]       commit_kind;
    logic [IDX_W:0]   rob_count;

    param_reorder_buffer #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB), .FULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_kind(alloc_kind),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .flush_in(flush_in),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_kind(commit_kind),
        .commit_mispredict(commit_mispredict), .rob_count(rob_count), .rob_empty(rob_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [1:0]  kind;
        bit          done;
        logic [31:0] value;
        bit          mp;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic        m_cv, m_cmp;
    logic [3:0]  m_ctag;
    logic [4:0]  m_cdest;
    logic [31:0] m_cval;
    logic [1:0]  m_ckind;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic int m_head();
        return (m_tail - q.size() + DEPTH) % DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0; m_cv = 0; m_cmp = 0; m_ctag = 0; m_cdest = 0; m_cval = 0; m_ckind = 0;
    endtask

    task automatic check_outputs();
        check_eq("rob_count", 32'(rob_count), 32'(q.size()));
        check_eq("rob_empty", 32'(rob_empty), 32'(q.size() == 0));
        check_eq("alloc_ready", 32'(alloc_ready), 32'((DEPTH - q.size()) > MARGIN));
        check_eq("alloc_tag", 32'(alloc_tag), 32'(m_tail));
        check_eq("commit_valid", 32'(commit_valid), 32'(m_cv));
        check_eq("commit_tag", 32'(commit_tag), 32'(m_ctag));
        check_eq("commit_dest", 32'(commit_dest), 32'(m_cdest));
        check_eq("commit_value", commit_value, m_cval);
        check_eq("commit_kind", 32'(commit_kind), 32'(m_ckind));
        check_eq("commit_mispredict", 32'(commit_mispredict), 32'(m_cmp));
    endtask

    // Apply the current inputs to the model as one clock edge
    task automatic model_step();
        int   head, t, i;
        bit   do_commit, alloc_ok;
        bit [DEPTH-1:0] claimed;
        ent_t h, e;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (flush_in) begin
            q.delete();
            m_tail = 0;
            m_cv = 0;
            return;
        end
        head = m_head();
        do_commit = (q.size() > 0) && q[0].done;
        if (do_commit) h = q[0];
        alloc_ok = alloc_valid && ((DEPTH - q.size()) > MARGIN);
        claimed = '0;
        for (int p = 0; p < WB; p++) begin
            if (wb_valid[p]) begin
                t = int'(wb_tag[p*IDX_W +: IDX_W]);
                if (!claimed[t]) begin
                    claimed[t] = 1'b1;
                    i = (t - head + DEPTH) % DEPTH;
                    if (i < q.size()) begin
                        e = q[i];
                        e.done = 1; e.value = wb_value[p*32 +: 32]; e.mp = wb_mispredict[p];
                        q[i] = e;
                    end
                end
            end
        end
        m_cv = do_commit;
        if (do_commit) begin
            m_ctag = 4'(head); m_cdest = h.dest; m_cval = h.value;
            m_ckind = h.kind; m_cmp = h.mp;
            void'(q.pop_front());
            if (h.mp) begin
                q.delete();
                m_tail = 0;
                alloc_ok = 0;
            end
        end
        if (alloc_ok) begin
            e.dest = alloc_dest; e.kind = alloc_kind; e.done = 0; e.value = 0; e.mp = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic drive_random(input int alloc_pct, input int wb_pct);
        int t;
        rst         = ($urandom_range(0, 299) == 0);
        rdy         = ($urandom_range(0, 9) != 0);
        flush_in    = ($urandom_range(0, 79) == 0);
        alloc_valid = ($urandom_range(0, 99) < alloc_pct);
        alloc_dest  = 5'($urandom);
        alloc_kind  = 2'($urandom);
        for (int p = 0; p < WB; p++) begin
            wb_valid[p]      = ($urandom_range(0, 99) < wb_pct);
            wb_mispredict[p] = ($urandom_range(0, 24) == 0);
            wb_value[p*32 +: 32] = $urandom;
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                t = (m_head() + int'($urandom_range(0, q.size() - 1))) % DEPTH;
            else
                t = int'($urandom_range(0, DEPTH - 1));
            if (p > 0 && $urandom_range(0, 3) == 0) t = int'(wb_tag[IDX_W-1:0]);
            wb_tag[p*IDX_W +: IDX_W] = 4'(t);
        end
    endtask

    int alloc_tab[4] = '{95, 60, 85, 40};
    int wb_tab[4]    = '{3, 30, 50, 70};

    initial begin
        rst = 1; rdy = 1; alloc_valid = 0; flush_in = 0; alloc_dest = 0; alloc_kind = 0;
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_mispredict = 0;
        model_reset();
        repeat (2) @(posedge clk);
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                check_outputs();
                drive_random(alloc_tab[ph], wb_tab[ph]);
                model_step();
            end
        end
        @(negedge clk);
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
